// File: rtl/demux_pkg.sv
// demux_pkg: channel count and select types shared by the registered demux
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    typedef logic [SEL_W-1:0] ch_idx_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one channel holding register with valid bit and delivery counter
module demux_slot #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          out_ready,
    output logic          free,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count
);
    assign free = !out_valid || out_ready;
    // load wins over drain so a full slot can swap words with no bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) out_count <= out_count + 1'b1;
        end
    end
endmodule

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: registered 1-to-4 demux with per-channel valid/ready and broadcast
module demux1to4_reg
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_bcast,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*W-1:0]  out_data,
    output logic [NUM_CH*CW-1:0] out_count
);
    logic [NUM_CH-1:0] free;
    logic              accept;
    // in_ready depends combinationally on out_ready through free
    assign in_ready = rst_n && (in_bcast ? &free : free[in_sel]);
    assign accept   = in_valid && in_ready;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        logic load;
        assign load = accept && (in_bcast || in_sel == ch_idx_t'(i));
        demux_slot #(.W(W), .CW(CW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .free      (free[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*W +: W]),
            .out_count (out_count[i*CW +: CW])
        );
    end
endmodule

// File: tb/tb_demux1to4_reg.sv
// tb_demux1to4_reg: directed vector table, streaming wrap and randomized run against a channel model
module tb_demux1to4_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_bcast = 1'b0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data;
    logic [31:0] out_count;

    int tests = 0;
    int fails = 0;
    logic last_ready;

    logic       mv [4];
    logic [7:0] md [4];
    int         delivered [4];

    demux1to4_reg #(.W(8), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [1:0]  s;
        logic        b;
        logic [7:0]  d;
        logic [3:0]  o;
        logic        er;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [31:0] ec;
    } vec_t;

    vec_t tv [20];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] s, input logic b,
                        input logic [7:0] d, input logic [3:0] o);
        logic       er;
        logic       all_free;
        logic [3:0] ev;
        logic [31:0] ed;
        logic [31:0] ec;
        rst_n = r; in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ready = o;
        #1;
        all_free = 1'b1;
        for (int i = 0; i < 4; i++) if (mv[i] && !o[i]) all_free = 1'b0;
        er = r && (b ? all_free : (!mv[s] || o[s]));
        last_ready = in_ready;
        chk("model in_ready", {63'd0, in_ready}, {63'd0, er});
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!r) begin
                mv[i] = 1'b0; md[i] = '0; delivered[i] = 0;
            end else begin
                logic drained;
                drained = mv[i] && o[i];
                if (drained) delivered[i]++;
                if (v && er && (b || int'(s) == i)) begin
                    mv[i] = 1'b1; md[i] = d;
                end else if (drained) begin
                    mv[i] = 1'b0;
                end
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            ev[i] = mv[i];
            ed[i*8 +: 8] = md[i];
            ec[i*8 +: 8] = 8'(delivered[i] % 256);
        end
        chk("model out_valid", {60'd0, out_valid}, {60'd0, ev});
        chk("model out_data", {32'd0, out_data}, {32'd0, ed});
        chk("model out_count", {32'd0, out_count}, {32'd0, ec});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0; md[i] = '0; delivered[i] = 0;
        end
        // reset with in_valid high
        tv[0]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 4'hF, 1'b0, 4'b0000, 32'h00000000, 32'h00000000};
        tv[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 4'hF, 1'b0, 4'b0000, 32'h00000000, 32'h00000000};
        // unicast sweep
        tv[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 32'h00000000};
        tv[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 32'h00000001};
        tv[4]  = '{1'b1, 1'b1, 2'd2, 1'b0, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 32'h00000101};
        tv[5]  = '{1'b1, 1'b1, 2'd3, 1'b0, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 32'h00010101};
        tv[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0, 32'h01010101};
        // backpressure on ch2, ch1 keeps flowing, release swaps with no bubble
        tv[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 8'h55, 4'b1011, 1'b1, 4'b0100, 32'hA355A1A0, 32'h01010101};
        tv[8]  = '{1'b1, 1'b1, 2'd2, 1'b0, 8'h66, 4'b1011, 1'b0, 4'b0100, 32'hA355A1A0, 32'h01010101};
        tv[9]  = '{1'b1, 1'b1, 2'd1, 1'b0, 8'h11, 4'b1011, 1'b1, 4'b0110, 32'hA35511A0, 32'h01010101};
        tv[10] = '{1'b1, 1'b1, 2'd2, 1'b0, 8'h66, 4'b1111, 1'b1, 4'b0100, 32'hA36611A0, 32'h01020201};
        // broadcast blocked by stalled ch3, then delivered to all four at once
        tv[11] = '{1'b1, 1'b1, 2'd3, 1'b0, 8'h33, 4'b0111, 1'b1, 4'b1000, 32'h336611A0, 32'h01030201};
        tv[12] = '{1'b1, 1'b1, 2'd0, 1'b1, 8'h7E, 4'b0111, 1'b0, 4'b1000, 32'h336611A0, 32'h01030201};
        tv[13] = '{1'b1, 1'b1, 2'd0, 1'b1, 8'h7E, 4'b1111, 1'b1, 4'b1111, 32'h7E7E7E7E, 32'h02030201};
        tv[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h7E7E7E7E, 32'h03040302};
        // reset mid-operation with slots 0 and 2 full
        tv[15] = '{1'b1, 1'b1, 2'd0, 1'b0, 8'hC0, 4'b0000, 1'b1, 4'b0001, 32'h7E7E7EC0, 32'h03040302};
        tv[16] = '{1'b1, 1'b1, 2'd2, 1'b0, 8'hC2, 4'b0000, 1'b1, 4'b0101, 32'h7EC27EC0, 32'h03040302};
        tv[17] = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h99, 4'b0000, 1'b0, 4'b0000, 32'h00000000, 32'h00000000};
        tv[18] = '{1'b1, 1'b1, 2'd1, 1'b0, 8'hD1, 4'b1111, 1'b1, 4'b0010, 32'h0000D100, 32'h00000000};
        tv[19] = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h0000D100, 32'h00000100};

        for (int k = 0; k < 20; k++) begin
            step(tv[k].r, tv[k].v, tv[k].s, tv[k].b, tv[k].d, tv[k].o);
            chk($sformatf("vec%0d in_ready", k), {63'd0, last_ready}, {63'd0, tv[k].er});
            chk($sformatf("vec%0d out_valid", k), {60'd0, out_valid}, {60'd0, tv[k].ev});
            chk($sformatf("vec%0d out_data", k), {32'd0, out_data}, {32'd0, tv[k].ed});
            chk($sformatf("vec%0d out_count", k), {32'd0, out_count}, {32'd0, tv[k].ec});
        end

        // 260 back-to-back words to ch0: one accept per cycle, counter wraps to 4
        for (int k = 0; k < 260; k++) begin
            step(1'b1, 1'b1, 2'd0, 1'b0, 8'(k), 4'hF);
            chk("stream in_ready", {63'd0, last_ready}, 64'd1);
        end
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        chk("stream wrap count0", {56'd0, out_count[7:0]}, 64'd4);

        // randomized traffic, occasional resets
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(31) != 0), 1'($urandom_range(1)), 2'($urandom_range(3)),
                 1'($urandom_range(3) == 0), 8'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demux1to4_reg.md
Name: demux1to4_reg

Overview:
- Registered 1-to-4 demultiplexer. It is the receive-side counterpart of the team's 4-to-1 tri-state select muxes.
- One source stream enters with a 2-bit destination select. Each word is delivered into one of four per-channel holding registers, or into all four in broadcast mode.
- Valid/ready handshakes on both sides.
- Sits between the shared select bus and four independent consumers, absorbing per-consumer stalls without losing data.

Parameters:
- W, 8, data width of every channel.
- CW, 8, width of each per-channel delivery counter (wraps modulo 2^CW).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  source presents a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  W  word to route.
- in_sel  input  2  destination channel 0..3; ignored when in_bcast=1.
- in_bcast  input  1  deliver word to all four channels atomically.
- out_valid  output  4  bit i: channel i holding register full.
- out_ready  input  4  bit i: consumer i takes the word this cycle.
- out_data  output  4*W  channel i occupies bits [i*W +: W].
- out_count  output  4*CW  channel i delivered-word counter, [i*CW +: CW].

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_data=0, out_count=0.
  - in_ready forced 0 combinationally while rst_n=0.
  - Reset mid-transfer discards all held words; no partial delivery.
- free[i] = !out_valid[i] || out_ready[i]. This is a combinational path from out_ready to in_ready; it is allowed and must be documented at integration.
- in_ready:
  - rst_n && free[in_sel] when in_bcast=0.
  - rst_n && (&free) when in_bcast=1.
- Accept = in_valid && in_ready.
  - Unicast: slot in_sel loads in_data.
  - Broadcast: all four slots load in_data in the same edge. Never a subset.
- Latency: word accepted at edge N is visible on out_valid/out_data from N+1.
- Slot i update per edge, with priority load > drain:
  - load: out_valid[i]<=1, out_data[i]<=in_data.
  - drain without load: out_valid[i]<=0. out_data[i] holds its value; it is not cleared.
  - Simultaneous drain and load on the same slot: the old word leaves and the new word occupies the slot. Full throughput of one word per cycle per channel, no bubble.
- Counter: out_count[i] increments by 1 on each edge where slot i drains (out_valid[i] && out_ready[i]). It wraps 2^CW-1 -> 0 silently.
- Protocol rules:
  - out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0.
  - in_data/in_sel/in_bcast are sampled only at accept.
  - in_ready may drop while in_valid=1 with no data loss; the source must hold.
- Independence: a stalled channel (out_ready[i]=0, full) blocks only unicasts to i and all broadcasts. The other channels keep flowing.
- X on in_sel when in_valid=0 must not affect state.

Decomposition:
- Package demux_pkg: NUM_CH=4, SEL_W=2, and a channel-index typedef.
- Sub-module demux_slot:
  - holds one channel register, valid bit and counter;
  - inputs: clk, rst_n, load, load_data, out_ready;
  - outputs: free, out_valid, out_data, out_count.
- Top instantiates four slots, computes in_ready and per-slot load, and packs the outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with in_valid=1 -> in_ready=0, out_valid=4'b0000, all counts 0. Release rst_n -> in_ready=1 the same cycle.
- Unicast sweep: send 0xA0..0xA3 with sel 0..3, out_ready=4'b1111 -> each word appears on the matching channel one cycle after accept. Each count=1 after drain. No other channel's out_valid rises.
- Backpressure:
  - out_ready[2]=0; send 0x55 then 0x66 to ch2 -> 0x55 held, in_ready=0 on the second word.
  - Meanwhile a send of 0x11 to ch1 is accepted.
  - Raise out_ready[2] -> 0x66 loads in that same edge; no bubble.
- Broadcast atomicity:
  - out_valid[3]=1 with out_ready[3]=0; request bcast 0x7E -> in_ready=0 and no slot changes.
  - Raise out_ready[3] -> all four show 0x7E next cycle.
- Streaming and wrap: CW=8, 260 back-to-back words to ch0 with out_ready=1 -> one accept per cycle, out_count[0]=4 after the final drain.
- Reset mid-operation: slots 0 and 2 full; assert rst_n=0 for one edge -> out_valid=0, counts=0, out_data=0. The next accepted word is delivered normally.
